input_symbol_conditioner: RTL and testbench
===========================================

// Module: input_symbol_conditioner
// PURPOSE
//   Upstream stage of the 6-state symbol FSM. Turns four raw, asynchronous,
//   bouncy request lines into the clean 2-bit input_signal symbol that the FSM consumes.
//   Synchronises, debounces and one-hot encodes; flags illegal multi-line presses.
//   input_signal is a held level; sym_valid marks each newly committed symbol.
// PARAMETERS
//   DEBOUNCE_CYCLES  4      consecutive identical synced samples needed to commit (>=1)
//   RESET_SYMBOL     2'b00  value of input_signal out of reset
//   Internal counter width = $clog2(DEBOUNCE_CYCLES+1) (localparam, not a port parameter)
// PORTS
//   clk           in   1  clock; all flops rise on posedge clk
//   reset         in   1  synchronous, active-high reset
//   raw_in        in   4  raw request lines, async; raw_in[i] requests symbol i
//   input_signal  out  2  committed symbol, held until next commit
//   sym_valid     out  1  one-cycle pulse, high in the cycle input_signal changes by commit
//   multi_err     out  1  high while in ERR (more than one line seen)
// BEHAVIOUR
//   Reset (sampled on posedge clk): input_signal=RESET_SYMBOL, sym_valid=0, multi_err=0,
//     sync flops=0, counter=0, cand=0, state=IDLE. It overrides every other event.
//   Sync: 2-flop synchroniser per line; sync = second flop; FSM uses sync only.
//   Classify sync: ZERO (4'b0000), ONE (exactly one bit set, enc = its index), MULTI (>=2 bits).
//   FSM states and transitions, evaluated each posedge:
//     IDLE:   ZERO -> stay. MULTI -> ERR.
//             ONE -> cand=enc, cnt=1, go COUNT. If DEBOUNCE_CYCLES==1, commit now and go LOCKED.
//     COUNT:  ONE && enc==cand -> cnt++. When this sample is the DEBOUNCE_CYCLES-th
//             consecutive match, commit and go LOCKED.
//             ONE && enc!=cand -> cand=enc, cnt=1, stay COUNT (restart).
//             ZERO -> IDLE, cnt=0. MULTI -> ERR, cnt=0.
//     LOCKED: ONE && enc==cand -> stay (held press; no repeat pulse). ZERO -> IDLE.
//             MULTI -> ERR. ONE && enc!=cand -> ERR (slide without release).
//     ERR:    multi_err=1. ZERO -> IDLE; any other input -> stay ERR.
//   Commit: input_signal<=cand and sym_valid<=1 for exactly one cycle.
//     sym_valid is 0 in every cycle without a commit.
//     A commit of the same value as the current input_signal still pulses sym_valid.
//   Latency: raw held from before edge 1 -> sync valid after edge 2 -> first sample at edge 3.
//     Commit at edge 2+DEBOUNCE_CYCLES (edge 6 for default 4).
//   input_signal never changes outside a commit or reset; ERR and IDLE leave it unchanged.
//   multi_err is registered: 1 in the cycle after entering ERR, 0 the cycle after leaving it.
//   Reset mid-COUNT/LOCKED/ERR: full restart. A full DEBOUNCE_CYCLES run is needed after
//     reset falls, and sync refills from 0.
//   Counter saturates by construction (leaves COUNT on commit); it never wraps.
// TESTING
//   T1 reset held 3 cycles, raw_in=4'b1111 -> input_signal=00, sym_valid=0, multi_err=0
//      throughout.
//   T2 raw_in=4'b0100 held 10 cycles (D=4) -> single sym_valid pulse after edge 6,
//      input_signal=2'b10; unchanged after raw returns to 0.
//   T3 raw_in 0010 for 2 cycles, 0000 for 1, then 0010 steady -> no pulse during bounce.
//      Pulse 4 samples after the steady run reaches sync; input_signal=2'b01.
//   T4 raw_in=4'b0011 steady -> multi_err=1 from the cycle after edge 3, no sym_valid.
//      input_signal held. raw=0 -> multi_err drops 1 cycle after sync clears.
//   T5 LOCKED on 0001 (symbol 00), switch directly to 1000 -> ERR, multi_err=1, no commit.
//      Release then 1000 for 4 samples -> commit 2'b11.
//   T6 reset asserted after 2 matching samples of 0100, released with 0100 still held ->
//      no pulse before edge 6 counted from reset release; then input_signal=2'b10.

Source files
------------

// File: rtl/input_symbol_conditioner.sv
// Conditions four raw, bouncy request lines into a committed 2-bit symbol.
// Each line is synchronised, then debounced, then encoded; simultaneous presses raise multi_err.
module input_symbol_conditioner #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [1:0] RESET_SYMBOL    = 2'b00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] raw_in,
   output logic [1:0] input_signal,
   output logic       sym_valid,
   output logic       multi_err
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      LOCKED,
      ERR
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      sync1_q, sync1_d;
   logic [3:0]      sync2_q, sync2_d;
   logic [1:0]      cand_q, cand_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sym_q, sym_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic            is_zero;
   logic            is_one;
   logic            is_multi;
   logic [1:0]      enc;

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
   end

   // A single set bit is the only pattern where clearing the lowest set bit leaves zero.
   always_comb begin
      is_zero  = (sync2_q == 4'b0000);
      is_one   = !is_zero && ((sync2_q & (sync2_q - 4'd1)) == 4'b0000);
      is_multi = !is_zero && !is_one;
      enc      = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i]) begin
            enc = i[1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      sym_d   = sym_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_multi) begin
               state_d = ERR;
               cnt_d   = '0;
            end else if (is_one) begin
               cand_d = enc;
               cnt_d  = CW'(1);
               if (DEBOUNCE_CYCLES == 1) begin
                  sym_d   = enc;
                  valid_d = 1'b1;
                  state_d = LOCKED;
               end else begin
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            if (is_one) begin
               if (enc == cand_q) begin
                  // This sample completes the run: commit and stop counting.
                  if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                     cnt_d   = CW'(DEBOUNCE_CYCLES);
                     sym_d   = cand_q;
                     valid_d = 1'b1;
                     state_d = LOCKED;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  cand_d = enc;
                  cnt_d  = CW'(1);
               end
            end else if (is_zero) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = ERR;
               cnt_d   = '0;
            end
         end
         LOCKED: begin
            if (is_zero) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (is_multi || (enc != cand_q)) begin
               // Sliding to another line without releasing is treated as illegal.
               state_d = ERR;
               cnt_d   = '0;
            end
         end
         ERR: begin
            if (is_zero) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      err_d = (state_d == ERR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         sym_q   <= RESET_SYMBOL;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign input_signal = sym_q;
   assign sym_valid    = valid_q;
   assign multi_err    = err_q;

endmodule

// File: tb/tb_input_symbol_conditioner.sv
// Scoreboard bench: each press pushes its expected commit edge and symbol; a monitor pops on sym_valid.
module tb_input_symbol_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] raw_in = 4'b1111;
   logic [1:0] input_signal;
   logic       sym_valid;
   logic       multi_err;

   int vectors = 0;
   int miscompares = 0;
   int edge_cnt = 0;

   typedef struct {
      int         at_edge;
      logic [1:0] sym;
   } exp_t;

   exp_t exp_q[$];

   input_symbol_conditioner #(.DEBOUNCE_CYCLES(D), .RESET_SYMBOL(2'b00)) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (raw_in),
      .input_signal (input_signal),
      .sym_valid    (sym_valid),
      .multi_err    (multi_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      exp_t e;
      if (sym_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: sym_valid=%b at edge %0d, required 0", sym_valid, edge_cnt);
         end else begin
            e = exp_q.pop_front();
            vectors++;
            if (edge_cnt != e.at_edge) begin
               miscompares++;
               $display("FAIL commit_edge: pulse at edge %0d, required edge %0d", edge_cnt, e.at_edge);
            end
            vectors++;
            if (input_signal !== e.sym) begin
               miscompares++;
               $display("FAIL commit_symbol: input_signal=%b, required %b", input_signal, e.sym);
            end
            $display("commit at edge %0d: input_signal=%b (expected edge %0d, symbol %b)",
                     edge_cnt, input_signal, e.at_edge, e.sym);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] pattern, input logic [1:0] sym);
      exp_t e;
      raw_in = pattern;
      e.at_edge = edge_cnt + 2 + D;
      e.sym = sym;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_missing_pulse: %0d commits outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (input_signal !== 2'b00 || sym_valid !== 1'b0 || multi_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: sig=%b valid=%b err=%b, required 00 0 0",
                     input_signal, sym_valid, multi_err);
         end
      end
      raw_in = 4'b0000;
      reset = 1'b0;
      tick(4);
      vectors++;
      if (input_signal !== 2'b00 || multi_err !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle: sig=%b err=%b, required 00 0", input_signal, multi_err);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_press();
      press(4'b0100, 2'b10);
      tick(10);
      raw_in = 4'b0000;
      tick(5);
      vectors++;
      if (input_signal !== 2'b10) begin
         miscompares++;
         $display("FAIL single_hold: input_signal=%b, required 10", input_signal);
      end
      check_drained("single");
   endtask

   task automatic test_bounce();
      raw_in = 4'b0010;
      tick(2);
      raw_in = 4'b0000;
      tick(1);
      press(4'b0010, 2'b01);
      tick(10);
      raw_in = 4'b0000;
      tick(5);
      vectors++;
      if (input_signal !== 2'b01) begin
         miscompares++;
         $display("FAIL bounce_symbol: input_signal=%b, required 01", input_signal);
      end
      check_drained("bounce");
   endtask

   task automatic test_multi();
      raw_in = 4'b0011;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         vectors++;
         if (multi_err !== (i >= 3)) begin
            miscompares++;
            $display("FAIL multi_rise: multi_err=%b after edge +%0d, required %b", multi_err, i, (i >= 3));
         end
      end
      raw_in = 4'b0000;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         vectors++;
         if (multi_err !== (i < 3)) begin
            miscompares++;
            $display("FAIL multi_fall: multi_err=%b after edge +%0d, required %b", multi_err, i, (i < 3));
         end
      end
      vectors++;
      if (input_signal !== 2'b01) begin
         miscompares++;
         $display("FAIL multi_hold: input_signal=%b, required 01", input_signal);
      end
      check_drained("multi");
   endtask

   task automatic test_slide();
      press(4'b0001, 2'b00);
      tick(8);
      raw_in = 4'b1000;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         vectors++;
         if (multi_err !== (i >= 3)) begin
            miscompares++;
            $display("FAIL slide_err: multi_err=%b after edge +%0d, required %b", multi_err, i, (i >= 3));
         end
      end
      vectors++;
      if (input_signal !== 2'b00) begin
         miscompares++;
         $display("FAIL slide_hold: input_signal=%b, required 00", input_signal);
      end
      raw_in = 4'b0000;
      tick(4);
      press(4'b1000, 2'b11);
      tick(8);
      vectors++;
      if (input_signal !== 2'b11) begin
         miscompares++;
         $display("FAIL slide_recommit: input_signal=%b, required 11", input_signal);
      end
      raw_in = 4'b0000;
      tick(4);
      check_drained("slide");
   endtask

   task automatic test_reset_mid_count();
      raw_in = 4'b0100;
      tick(4);
      reset = 1'b1;
      tick(2);
      vectors++;
      if (input_signal !== 2'b00 || sym_valid !== 1'b0 || multi_err !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_state: sig=%b valid=%b err=%b, required 00 0 0",
                  input_signal, sym_valid, multi_err);
      end
      reset = 1'b0;
      press(4'b0100, 2'b10);
      tick(9);
      vectors++;
      if (input_signal !== 2'b10) begin
         miscompares++;
         $display("FAIL midreset_commit: input_signal=%b, required 10", input_signal);
      end
      raw_in = 4'b0000;
      tick(4);
      check_drained("midreset");
   endtask

   task automatic test_back_to_back();
      // Same symbol again still pulses, then an immediate different press commits too.
      press(4'b0100, 2'b10);
      tick(7);
      raw_in = 4'b0000;
      tick(3);
      press(4'b0010, 2'b01);
      tick(8);
      raw_in = 4'b0000;
      tick(4);
      vectors++;
      if (input_signal !== 2'b01) begin
         miscompares++;
         $display("FAIL b2b_symbol: input_signal=%b, required 01", input_signal);
      end
      check_drained("b2b");
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_slide();
      test_reset_mid_count();
      test_back_to_back();
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
